// File: rtl/div_32_if.sv
// Request/result bundle between the EX stage and the iterative divider.
// DIV_SIGNED_EN adds the is_signed request bit.
interface div_32_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
  logic             is_signed;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
`ifdef DIV_SIGNED_EN
    output is_signed,
`endif
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
`ifdef DIV_SIGNED_EN
    input  is_signed,
`endif
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div_32.sv
// Restoring shift-and-subtract divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to add two's-complement operation via is_signed.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// CALC   | WIDTH iterations of shift / trial-subtract
// FINISH | sign fix-up, load results, pulse done
module div_32 #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  div_32_if.slave  div_io
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] rem_q, dvd_q, dsr_q;
  logic [WIDTH-1:0] quot_q, remo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, div_zero_q, dz_q;

  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] a_abs, b_abs, q_fix, r_fix;

  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dsr_q};

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg, neg_q, rneg_q;
  assign a_neg = div_io.is_signed & div_io.dividend[WIDTH-1];
  assign b_neg = div_io.is_signed & div_io.divisor[WIDTH-1];
  assign a_abs = a_neg ? -div_io.dividend : div_io.dividend;
  assign b_abs = b_neg ? -div_io.divisor  : div_io.divisor;
  assign q_fix = neg_q  ? -dvd_q : dvd_q;
  assign r_fix = rneg_q ? -rem_q : rem_q;
`else
  assign a_abs = div_io.dividend;
  assign b_abs = div_io.divisor;
  assign q_fix = dvd_q;
  assign r_fix = rem_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      quot_q     <= '0;
      remo_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      dz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (div_io.start) begin
            busy_q     <= 1'b1;
            div_zero_q <= 1'b0;
            cnt_q      <= '0;
            if (div_io.divisor == '0) begin
              // raw dividend parked in the shift register becomes the remainder
              dz_q    <= 1'b1;
              dvd_q   <= div_io.dividend;
              state_q <= FINISH;
            end else begin
              dz_q    <= 1'b0;
              rem_q   <= '0;
              dvd_q   <= a_abs;
              dsr_q   <= b_abs;
`ifdef DIV_SIGNED_EN
              neg_q   <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
`endif
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          dvd_q <= {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
          rem_q <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1))
            state_q <= FINISH;
        end
        FINISH: begin
          // divide-by-zero spends one extra cycle here so done lands at E0+2
          if (dz_q && cnt_q == '0) begin
            cnt_q <= CW'(1);
          end else begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
            if (dz_q) begin
              quot_q     <= '1;
              remo_q     <= dvd_q;
              div_zero_q <= 1'b1;
            end else begin
              quot_q     <= q_fix;
              remo_q     <= r_fix;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_io.busy      = busy_q;
  assign div_io.done      = done_q;
  assign div_io.quotient  = quot_q;
  assign div_io.remainder = remo_q;
  assign div_io.div_zero  = div_zero_q;
endmodule

// File: tb/tb_div_32.sv
// Directed bench for div_32: vector table plus handshake/reset corner sequences.
module tb_div_32;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  div_32_if #(.WIDTH(32)) dif();

  div_32 #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_io (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    int          lat;
    logic [31:0] q;
    logic [31:0] r;
    bit          z;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (dif.done) begin
        n = c;
        return;
      end
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input bit s);
    dif.dividend = a;
    dif.divisor  = b;
`ifdef DIV_SIGNED_EN
    dif.is_signed = s;
`else
    if (s) $display("note: signed vector driven in unsigned build");
`endif
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int n;
    @(negedge clk);
    dif.start = 1'b1;
    drive(v.a, v.b, v.s);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    drive(~v.a, v.b ^ 32'h5A5A_0001, ~v.s);
    chk({name, ".busy"}, 32'(dif.busy), 32'd1);
    wait_done(n);
    chk({name, ".lat"}, 32'(n), 32'(v.lat));
    chk({name, ".q"}, dif.quotient, v.q);
    chk({name, ".r"}, dif.remainder, v.r);
    chk({name, ".dz"}, 32'(dif.div_zero), 32'(v.z));
    chk({name, ".busy_end"}, 32'(dif.busy), 32'd0);
    @(posedge clk);
    #1;
    chk({name, ".done_pulse"}, 32'(dif.done), 32'd0);
    chk({name, ".q_hold"}, dif.quotient, v.q);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    bit   seen;
    vec_t v;

    vecs.push_back('{32'd100,        32'd7,          1'b0, 33, 32'd14,         32'd2,          1'b0});
    vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 33, 32'hFFFF_FFFF,  32'd0,          1'b0});
    vecs.push_back('{32'd5,          32'd9,          1'b0, 33, 32'd0,          32'd5,          1'b0});
    vecs.push_back('{32'd1234,       32'd0,          1'b0,  2, 32'hFFFF_FFFF,  32'd1234,       1'b1});
    vecs.push_back('{32'd0,          32'd5,          1'b0, 33, 32'd0,          32'd0,          1'b0});
    vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 33, 32'd1,          32'd0,          1'b0});
    vecs.push_back('{32'h8000_0000,  32'd3,          1'b0, 33, 32'h2AAA_AAAA,  32'd2,          1'b0});
    vecs.push_back('{32'd1000000,    32'd1000,       1'b0, 33, 32'd1000,       32'd0,          1'b0});
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, 33, 32'h7FFF_FFFC,  32'd1,          1'b0});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 33, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 33, 32'h8000_0000,  32'd0,          1'b0});
    vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 33, 32'hFFFF_FFFD,  32'd1,          1'b0});
    vecs.push_back('{32'hFFFF_FFF8,  32'hFFFF_FFFE,  1'b1, 33, 32'd4,          32'd0,          1'b0});
    vecs.push_back('{32'hFFFF_FFF9,  32'd0,          1'b1,  2, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1});
`endif

    dif.start = 1'b0;
    drive(32'd0, 32'd0, 1'b0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(dif.busy), 32'd0);
    chk("rst.done", 32'(dif.done), 32'd0);
    chk("rst.q", dif.quotient, 32'd0);
    chk("rst.r", dif.remainder, 32'd0);
    chk("rst.dz", 32'(dif.div_zero), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec($sformatf("v%0d", i), vecs[i]);

    // start re-asserted mid-CALC with new operands must be ignored
    @(negedge clk);
    dif.start = 1'b1;
    drive(32'd100, 32'd7, 1'b0);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    dif.start = 1'b1;
    drive(32'd50, 32'd5, 1'b0);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_done(n);
    chk("midstart.lat", 32'(n), 32'd22);
    chk("midstart.q", dif.quotient, 32'd14);
    chk("midstart.r", dif.remainder, 32'd2);

    // start held through done: second op accepted on the edge after done
    @(negedge clk);
    dif.start = 1'b1;
    drive(32'd100, 32'd7, 1'b0);
    @(posedge clk);
    #1;
    drive(32'd5, 32'd9, 1'b0);
    wait_done(n);
    chk("held1.lat", 32'(n), 32'd33);
    chk("held1.q", dif.quotient, 32'd14);
    chk("held1.r", dif.remainder, 32'd2);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    chk("held2.busy", 32'(dif.busy), 32'd1);
    wait_done(n);
    chk("held2.lat", 32'(n), 32'd33);
    chk("held2.q", dif.quotient, 32'd0);
    chk("held2.r", dif.remainder, 32'd5);

    // reset ten cycles into CALC aborts with no done pulse
    run_vec("pre_rst", '{32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0});
    @(negedge clk);
    dif.start = 1'b1;
    drive(32'd1000, 32'd3, 1'b0);
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(dif.busy), 32'd0);
    chk("abort.done", 32'(dif.done), 32'd0);
    chk("abort.q", dif.quotient, 32'd0);
    chk("abort.r", dif.remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (dif.done || dif.busy) seen = 1'b1;
    end
    chk("abort.quiet", 32'(seen), 32'd0);
    v = '{32'd1000, 32'd3, 1'b0, 33, 32'd333, 32'd1, 1'b0};
    run_vec("post_rst", v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
